// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions: base opcodes, the canonical NOP and immediate formats.
package rv32i_pkg;

    localparam logic [6:0] OP     = 7'b0110011;
    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] STORE  = 7'b0100011;
    localparam logic [6:0] BRANCH = 7'b1100011;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] JALR   = 7'b1100111;
    localparam logic [6:0] LUI    = 7'b0110111;
    localparam logic [6:0] AUIPC  = 7'b0010111;

    // ADDI x0,x0,0
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [2:0] {
        FmtI,
        FmtS,
        FmtB,
        FmtU,
        FmtJ,
        FmtNone
    } imm_fmt_e;

    // Immediate format implied by an opcode; R-type and unknown opcodes carry none.
    function automatic imm_fmt_e imm_fmt(input logic [6:0] opcode);
        case (opcode)
            LOAD, OP_IMM, JALR: return FmtI;
            STORE:              return FmtS;
            BRANCH:             return FmtB;
            LUI, AUIPC:         return FmtU;
            JAL:                return FmtJ;
            default:            return FmtNone;
        endcase
    endfunction

    function automatic logic is_legal(input logic [6:0] opcode);
        case (opcode)
            OP, OP_IMM, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC: return 1'b1;
            default:                                               return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/regfile.sv
// 32x32 register file: two async read ports with write-through bypass, one sync write port.
module regfile (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_we,
    input  logic [4:0]  i_waddr,
    input  logic [31:0] i_wdata,
    input  logic [4:0]  i_raddr1,
    input  logic [4:0]  i_raddr2,
    output logic [31:0] o_rdata1,
    output logic [31:0] o_rdata2
);

    logic [31:0] r_mem [32];
    logic        w_wr_ok;

    assign w_wr_ok = i_we && (i_waddr != 5'd0);

    // Clear on reset; x0 is never written.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < 32; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_wr_ok) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Reads see a same-cycle write so decode never consumes a stale value.
    always_comb begin
        o_rdata1 = r_mem[i_raddr1];
        o_rdata2 = r_mem[i_raddr2];
        if (w_wr_ok && (i_waddr == i_raddr1)) o_rdata1 = i_wdata;
        if (w_wr_ok && (i_waddr == i_raddr2)) o_rdata2 = i_wdata;
        if (i_raddr1 == 5'd0) o_rdata1 = '0;
        if (i_raddr2 == 5'd0) o_rdata2 = '0;
    end

endmodule

// File: rtl/decode.sv
// RV32I decode stage: register read, immediate generation, load-use hazard detection
// and the registered operand/control bundle handed to execute.
module decode
    import rv32i_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        req,
    input  logic        reset,
    input  logic        stall_in,
    input  logic        flush_in,
    input  logic        valid_in,
    input  logic [31:0] instr_in,
    input  logic [31:0] pc_in,
    input  logic        wb_en_in,
    input  logic [4:0]  wb_rd_in,
    input  logic [31:0] wb_value_in,
    input  logic [4:0]  ex_rd_in,
    input  logic        ex_is_load_in,
    output logic        stall_out,
    output logic        valid_out,
    output logic [6:0]  alu_opcode_out,
    output logic [2:0]  alu_funct3_out,
    output logic [6:0]  alu_funct7_out,
    output logic [31:0] rs1_value_out,
    output logic [31:0] rs2_value_out,
    output logic [31:0] imm_value_out,
    output logic [31:0] pc_co_out,
    output logic [4:0]  rd_out,
    output logic        illegal_out
);

    logic [6:0]  w_opcode;
    logic [4:0]  w_rs1_idx;
    logic [4:0]  w_rs2_idx;
    logic [31:0] w_rs1_val;
    logic [31:0] w_rs2_val;
    logic [31:0] w_imm;
    logic        w_rs1_used;
    logic        w_rs2_used;
    logic        w_hazard;
    imm_fmt_e    w_fmt;

    logic        r_valid;
    logic [6:0]  r_opcode;
    logic [2:0]  r_funct3;
    logic [6:0]  r_funct7;
    logic [31:0] r_rs1;
    logic [31:0] r_rs2;
    logic [31:0] r_imm;
    logic [31:0] r_pc;
    logic [4:0]  r_rd;
    logic        r_illegal;

    assign w_opcode  = instr_in[6:0];
    assign w_rs1_idx = instr_in[19:15];
    assign w_rs2_idx = instr_in[24:20];
    assign w_fmt     = imm_fmt(w_opcode);

    regfile u_regfile (
        .i_clk    (req),
        .i_rst    (reset),
        .i_we     (wb_en_in),
        .i_waddr  (wb_rd_in),
        .i_wdata  (wb_value_in),
        .i_raddr1 (w_rs1_idx),
        .i_raddr2 (w_rs2_idx),
        .o_rdata1 (w_rs1_val),
        .o_rdata2 (w_rs2_val)
    );

    // Sign-extended immediate assembled from the format's scattered fields.
    always_comb begin
        w_imm = '0;
        case (w_fmt)
            FmtI:    w_imm = {{20{instr_in[31]}}, instr_in[31:20]};
            FmtS:    w_imm = {{20{instr_in[31]}}, instr_in[31:25], instr_in[11:7]};
            FmtB:    w_imm = {{19{instr_in[31]}}, instr_in[31], instr_in[7],
                              instr_in[30:25], instr_in[11:8], 1'b0};
            FmtU:    w_imm = {instr_in[31:12], 12'h000};
            FmtJ:    w_imm = {{11{instr_in[31]}}, instr_in[31], instr_in[19:12],
                              instr_in[20], instr_in[30:21], 1'b0};
            default: w_imm = '0;
        endcase
    end

    // Only fields that are really source registers may raise a load-use hazard.
    always_comb begin
        w_rs1_used = !((w_opcode == LUI) || (w_opcode == AUIPC) || (w_opcode == JAL));
        w_rs2_used = (w_opcode == OP) || (w_opcode == STORE) || (w_opcode == BRANCH);
        w_hazard   = valid_in && ex_is_load_in && (ex_rd_in != 5'd0) &&
                     ((w_rs1_used && (w_rs1_idx == ex_rd_in)) ||
                      (w_rs2_used && (w_rs2_idx == ex_rd_in)));
    end

    assign stall_out = stall_in | (w_hazard & ~flush_in);

    // Bundle register: stall holds, flush/hazard/empty slot inserts a bubble.
    always_ff @(posedge req or posedge reset) begin
        if (reset) begin
            r_valid   <= 1'b0;
            r_opcode  <= NOP[6:0];
            r_funct3  <= '0;
            r_funct7  <= '0;
            r_rs1     <= '0;
            r_rs2     <= '0;
            r_imm     <= '0;
            r_pc      <= RESET_PC;
            r_rd      <= '0;
            r_illegal <= 1'b0;
        end else if (!stall_in) begin
            if (flush_in || w_hazard || !valid_in) begin
                r_valid   <= 1'b0;
                r_opcode  <= NOP[6:0];
                r_funct3  <= '0;
                r_funct7  <= '0;
                r_rs1     <= '0;
                r_rs2     <= '0;
                r_imm     <= '0;
                r_pc      <= RESET_PC;
                r_rd      <= '0;
                r_illegal <= 1'b0;
            end else begin
                r_valid   <= 1'b1;
                r_opcode  <= w_opcode;
                r_funct3  <= instr_in[14:12];
                r_funct7  <= instr_in[31:25];
                r_rs1     <= w_rs1_val;
                r_rs2     <= w_rs2_val;
                r_imm     <= w_imm;
                r_pc      <= pc_in;
                r_rd      <= instr_in[11:7];
                r_illegal <= !is_legal(w_opcode);
            end
        end
    end

    assign valid_out      = r_valid;
    assign alu_opcode_out = r_opcode;
    assign alu_funct3_out = r_funct3;
    assign alu_funct7_out = r_funct7;
    assign rs1_value_out  = r_rs1;
    assign rs2_value_out  = r_rs2;
    assign imm_value_out  = r_imm;
    assign pc_co_out      = r_pc;
    assign rd_out         = r_rd;
    assign illegal_out    = r_illegal;

endmodule
